// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: shares a bank of WIDTH JK cells between two command
// requesters. Each accepted command becomes one cycle of J/K drive on the
// target cell, followed by a read-back of that cell's Q as a response.
//
// Optional feature macro: JK_ARB_CHECK_EN
//   When defined, adds output rsp_err, which flags a response whose Q does
//   not match the value the command should have produced.
//
// State table
//   state     | meaning
//   S_IDLE    | waiting for a request; ready asserted to the granted port
//   S_DRIVE   | registered J/K drive on the target cell for one cycle
//   S_CAPTURE | J/K released; target Q sampled into the response on exit
module jk_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IDX_W-1:0] req0_idx,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IDX_W-1:0] req1_idx,
  input  logic [1:0]       req1_op,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] jk_q,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_q
`ifdef JK_ARB_CHECK_EN
  ,
  output logic             rsp_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_last_grant;
  logic             r_id;
  logic [IDX_W-1:0] r_idx;
  logic             r_oor;

  logic [WIDTH-1:0] r_jk_j;
  logic [WIDTH-1:0] r_jk_k;
  logic [WIDTH-1:0] w_jk_j_nxt;
  logic [WIDTH-1:0] w_jk_k_nxt;
  logic [WIDTH-1:0] w_dec_j;
  logic [WIDTH-1:0] w_dec_k;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_acc_id;
  logic [IDX_W-1:0] w_acc_idx;
  logic [1:0]       w_acc_op;
  logic             w_acc_oor;
  logic             w_q_sel;

  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic             r_rsp_q;

  // Round-robin grant, only offered while idle. last_grant=1 after reset
  // so port 0 wins the first tie.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == S_IDLE) begin
      if (req0_valid && (!req1_valid || r_last_grant)) begin
        w_grant0 = 1'b1;
      end else if (req1_valid) begin
        w_grant1 = 1'b1;
      end
    end
  end

  assign w_accept   = w_grant0 | w_grant1;
  assign w_acc_id   = w_grant1;
  assign w_acc_idx  = w_grant1 ? req1_idx : req0_idx;
  assign w_acc_op   = w_grant1 ? req1_op  : req0_op;
  assign w_acc_oor  = (int'(w_acc_idx) >= WIDTH);
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // One-hot op decode for the accepted command; an out-of-range index
  // matches no bit, so such a command degenerates to hold.
  always_comb begin
    w_dec_j = '0;
    w_dec_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_acc_idx == IDX_W'(i)) begin
        w_dec_j[i] = w_acc_op[0];
        w_dec_k[i] = w_acc_op[1];
      end
    end
  end

  // Q of the latched target cell; out-of-range targets read as 0.
  always_comb begin
    w_q_sel = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!r_oor && (r_idx == IDX_W'(i))) begin
        w_q_sel = jk_q[i];
      end
    end
  end

  // Next-state and next J/K drive; J/K are nonzero only for the DRIVE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_jk_j_nxt  = '0;
    w_jk_k_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_DRIVE;
          w_jk_j_nxt  = w_dec_j;
          w_jk_k_nxt  = w_dec_k;
        end
      end
      S_DRIVE:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register and registered J/K drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_jk_j  <= '0;
      r_jk_k  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_jk_j  <= w_jk_j_nxt;
      r_jk_k  <= w_jk_k_nxt;
    end
  end

  // Latch the accepted command and remember who was granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_idx        <= '0;
      r_oor        <= 1'b0;
    end else if (w_accept) begin
      r_last_grant <= w_acc_id;
      r_id         <= w_acc_id;
      r_idx        <= w_acc_idx;
      r_oor        <= w_acc_oor;
    end
  end

  // Response: sampled on the CAPTURE exit edge, valid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_q     <= 1'b0;
    end else begin
      r_rsp_valid <= (r_state == S_CAPTURE);
      if (r_state == S_CAPTURE) begin
        r_rsp_id <= r_id;
        r_rsp_q  <= w_q_sel;
      end
    end
  end

  assign jk_j      = r_jk_j;
  assign jk_k      = r_jk_k;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_q     = r_rsp_q;

`ifdef JK_ARB_CHECK_EN
  logic       r_pre;
  logic [1:0] r_op;
  logic       w_pre_sel;
  logic       w_exp_q;
  logic       r_rsp_err;

  // Pre-command Q of the target being accepted.
  always_comb begin
    w_pre_sel = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_acc_idx == IDX_W'(i)) begin
        w_pre_sel = jk_q[i];
      end
    end
  end

  // Value the cell should hold once the command has been applied.
  always_comb begin
    w_exp_q = r_pre;
    case (r_op)
      OP_HOLD:   w_exp_q = r_pre;
      OP_SET:    w_exp_q = 1'b1;
      OP_RESET:  w_exp_q = 1'b0;
      OP_TOGGLE: w_exp_q = ~r_pre;
      default:   w_exp_q = r_pre;
    endcase
  end

  // Latch pre-value and effective op; out-of-range commands act as hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= 1'b0;
      r_op  <= OP_HOLD;
    end else if (w_accept) begin
      r_pre <= w_pre_sel;
      r_op  <= w_acc_oor ? OP_HOLD : w_acc_op;
    end
  end

  // Error flag travels with rsp_valid; never raised for out-of-range targets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_err <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_rsp_err <= !r_oor && (w_q_sel != w_exp_q);
    end else begin
      r_rsp_err <= 1'b0;
    end
  end

  assign rsp_err = r_rsp_err;
`endif

endmodule
